pcie_rq_arbiter: RTL
====================

# pcie_rq_arbiter

Packet-granular round-robin arbiter that shares the single PCIe requester-request (RQ) AXI4-Stream channel among `NUM_REQ` internal requesters, such as NVMe DMA read, DMA write and doorbell engines. It sits between those engines and the `s_axis_rq_*` port of the PCIe IP, inside `pcie_arbiter`. A grant is held from the first beat to the `tlast` beat, so TLPs from different requesters never interleave.

## Interface
Parameters:
- `C_DATA_WIDTH`, 128: RQ data width.
- `AXI4_RQ_TUSER_WIDTH`, 62: RQ tuser width.
- `KEEP_WIDTH`, `C_DATA_WIDTH/32`: tkeep width.
- `NUM_REQ`, 4: number of requesters. Range 2..8.

Ports:
- `user_clk`  in  1: the only clock.
- `user_reset`  in  1: reset, synchronous, active-high.
- `user_lnk_up`  in  1: link up. New grants are issued only while this is high.
- `req_tdata`  in  `NUM_REQ*C_DATA_WIDTH`: requester data. Requester i occupies slice i.
- `req_tuser`  in  `NUM_REQ*AXI4_RQ_TUSER_WIDTH`: requester tuser, same slicing.
- `req_tkeep`  in  `NUM_REQ*KEEP_WIDTH`: requester tkeep, same slicing.
- `req_tlast`  in  `NUM_REQ`: requester tlast.
- `req_tvalid`  in  `NUM_REQ`: requester tvalid.
- `req_tready`  out  `NUM_REQ`: requester tready.
- `s_axis_rq_tdata`  out  `C_DATA_WIDTH`: data to the IP.
- `s_axis_rq_tuser`  out  `AXI4_RQ_TUSER_WIDTH`: tuser to the IP.
- `s_axis_rq_tkeep`  out  `KEEP_WIDTH`: tkeep to the IP.
- `s_axis_rq_tlast`  out  1: tlast to the IP.
- `s_axis_rq_tvalid`  out  1: tvalid to the IP.
- `s_axis_rq_tready`  in  4: IP ready. Only bit 0 is used.
- `arb_grant`  out  `NUM_REQ`: one-hot current grant. All zeros when idle.
- `arb_busy`  out  1: high while in BUSY.
- `stat_pkt_cnt`  out  `NUM_REQ*32`: per-requester packet counters. Present only with `PCIE_RQ_ARB_STAT_EN`.

## Operation
- State machine with two states.
- **IDLE:**
  - Grant is all zeros; all `req_tready` are 0; `s_axis_rq_tvalid` is 0.
  - If `user_lnk_up` is high and any `req_tvalid` is high, select the first valid requester searching from `last_grant+1` upward, modulo `NUM_REQ`.
  - Register the selection into `arb_grant` and `gidx`, then go to BUSY.
- **BUSY:**
  - Forward requester `gidx` to the IP: `s_axis_rq_tdata/tuser/tkeep/tlast` = slice `gidx`.
  - `s_axis_rq_tvalid` = `req_tvalid[gidx]`.
  - `req_tready[gidx]` = `s_axis_rq_tready[0]`; every other `req_tready` is 0.
  - On a beat with `tvalid && tready[0] && tlast`: set `last_grant <= gidx`, clear the grant, return to IDLE.
- Requesters that are not granted always see `tready` = 0.
- While BUSY, a granted requester may drop `tvalid` mid-packet; the grant is held until its `tlast` beat.
- `user_lnk_up` falling while BUSY does not abort the packet; the in-flight packet completes normally.
- `user_lnk_up` low in IDLE: no grant is issued, regardless of `req_tvalid`.
- `user_reset` in any state, including mid-packet:
  - Next state is IDLE; `arb_grant` = 0; `last_grant` = `NUM_REQ-1`, so requester 0 has first priority after reset.
  - Counters clear to 0.
  - A packet cut by reset is the requester's responsibility to drop; the arbiter does not complete it.

## Timing
- Arbitration latency: a requester raising `tvalid` in IDLE in cycle N gets its first forwarded beat in cycle N+1.
- The datapath is a combinational mux in BUSY. There is no data register, so data latency is 0 cycles.
- `tvalid` and `tready` pass through in the same cycle.
- Packet-to-packet gap is exactly 1 idle cycle, including when the same requester sends back-to-back packets.
- A single-beat packet occupies BUSY for one handshake cycle.
- Reset values:
  - `s_axis_rq_tvalid` = 0, `req_tready` = 0, `arb_grant` = 0, `arb_busy` = 0, `stat_pkt_cnt` = 0.
  - Data outputs (`tdata`, `tuser`, `tkeep`, `tlast`) are don't-care while `tvalid` is 0. They drive slice 0, not X.

## Configuration
- `PCIE_RQ_ARB_STAT_EN` defined:
  - One 32-bit counter per requester, incremented on each `tlast` handshake of that requester.
  - Counters wrap from `0xFFFF_FFFF` to 0.
  - They are exported on `stat_pkt_cnt`.
- Not defined: the `stat_pkt_cnt` port and all counter logic are absent.

## Structure
- Shared package `pcie_arb_pkg` holds:
  - The state typedef (`ARB_IDLE`, `ARB_BUSY`).
  - The `MAX_NUM_REQ` = 8 constant.
  - The round-robin next-index function.
- One sub-module, `rr_select`: combinational. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and the index. It is reused later by the CC-side arbiter.

## Test plan
- **Single requester:** reset, link up, req0 sends a 3-beat packet.
  - Forwarded beats in cycles 1–3 after `tvalid`.
  - `arb_grant` = `4'b0001`; IDLE on the cycle after `tlast`.
- **Fairness:** all four requesters hold `tvalid` continuously with 2-beat packets.
  - Grant order is 0,1,2,3,0.
  - Exactly 1 idle cycle between packets.
- **Backpressure:** `s_axis_rq_tready[0]` low for 5 cycles mid-packet from req2.
  - Beat held stable; `req_tready[2]` low for those cycles.
  - No other requester's `tready` rises.
- **Link down:** `user_lnk_up` = 0 with req1 valid → no grant for 10 cycles. Link goes up → req1 granted on the next cycle.
- **Reset mid-packet:** assert `user_reset` on beat 2 of a 4-beat req3 packet.
  - Next cycle: IDLE, all outputs at reset values.
  - With req0 and req3 both valid afterwards, req0 is granted first.
- **Counters (`PCIE_RQ_ARB_STAT_EN`):** preload the req1 counter to `0xFFFF_FFFE`, send 3 packets from req1.
  - Counter reads `0xFFFF_FFFF`, then 0, then 1.
  - Other counters unchanged.

Source files
------------

// File: rtl/pcie_arb_pkg.sv
// Shared definitions for the PCIe request arbiters: FSM state type, the
// requester-count ceiling and the round-robin search helper.
package pcie_arb_pkg;

  localparam int MAX_NUM_REQ = 8;
  localparam int ARB_IDX_W   = 3;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // First set bit of req searching upward from last+1, wrapping at num.
  // Returns last when nothing is requesting.
  function automatic logic [ARB_IDX_W-1:0] rr_next_idx(
    input logic [MAX_NUM_REQ-1:0] req,
    input logic [ARB_IDX_W-1:0]   last,
    input logic [ARB_IDX_W:0]     num
  );
    logic [ARB_IDX_W-1:0] idx;
    logic                 found;
    logic [ARB_IDX_W:0]   cand;
    idx   = last;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= MAX_NUM_REQ; k++) begin
      cand = {1'b0, last} + 4'(k);
      cand = (cand >= num) ? (cand - num) : cand;
      if ((4'(k) <= num) && !found && req[cand[ARB_IDX_W-1:0]]) begin
        idx   = cand[ARB_IDX_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pcie_rq_arbiter_rr_select.sv
// Combinational round-robin selector: one-hot grant and index of the next
// requester after last_grant_i. Shared with the completer-side arbiter.
module rr_select
  import pcie_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [MAX_NUM_REQ-1:0] req_ext_s;
  logic [ARB_IDX_W-1:0]   last_ext_s;

  // Widen to the package search width and pick the next requester
  always_comb begin
    req_ext_s                  = '0;
    req_ext_s[NUM_REQ-1:0]     = req_i;
    last_ext_s                 = '0;
    last_ext_s[IDX_W-1:0]      = last_grant_i;
    valid_o                    = |req_i;
    idx_o                      = IDX_W'(rr_next_idx(req_ext_s, last_ext_s, 4'(NUM_REQ)));
    grant_o                    = '0;
    if (valid_o) begin
      grant_o[idx_o] = 1'b1;
    end else begin
      grant_o = '0;
    end
  end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// Packet-granular round-robin arbiter onto the PCIe RQ AXI4-Stream port.
// Optional per-requester packet counters: define PCIE_RQ_ARB_STAT_EN.
module pcie_rq_arbiter
  import pcie_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH        = 128,
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int NUM_REQ             = 4
) (
  input  logic                                   user_clk,
  input  logic                                   user_reset,
  input  logic                                   user_lnk_up,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]        req_tdata,
  input  logic [NUM_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]          req_tkeep,
  input  logic [NUM_REQ-1:0]                     req_tlast,
  input  logic [NUM_REQ-1:0]                     req_tvalid,
  output logic [NUM_REQ-1:0]                     req_tready,
  output logic [C_DATA_WIDTH-1:0]                s_axis_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0]         s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]                  s_axis_rq_tkeep,
  output logic                                   s_axis_rq_tlast,
  output logic                                   s_axis_rq_tvalid,
  input  logic [3:0]                             s_axis_rq_tready,
  output logic [NUM_REQ-1:0]                     arb_grant,
  output logic                                   arb_busy
`ifdef PCIE_RQ_ARB_STAT_EN
  ,
  output logic [NUM_REQ*32-1:0]                  stat_pkt_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [IDX_W-1:0]     last_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   sel_grant_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 sel_valid_s;
  logic                 beat_last_s;
  logic                 tready_unused_s;

  logic [C_DATA_WIDTH-1:0]        data_a_s [NUM_REQ];
  logic [AXI4_RQ_TUSER_WIDTH-1:0] user_a_s [NUM_REQ];
  logic [KEEP_WIDTH-1:0]          keep_a_s [NUM_REQ];

  assign tready_unused_s = ^s_axis_rq_tready[3:1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_a_s[g] = req_tdata[g*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign user_a_s[g] = req_tuser[g*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
    assign keep_a_s[g] = req_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
  end

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req_i        (req_tvalid),
    .last_grant_i (last_q),
    .grant_o      (sel_grant_s),
    .idx_o        (sel_idx_s),
    .valid_o      (sel_valid_s)
  );

  // Forwarding mux; gidx_q resets to 0 so idle data shows slice 0, not X
  always_comb begin
    s_axis_rq_tdata  = data_a_s[gidx_q];
    s_axis_rq_tuser  = user_a_s[gidx_q];
    s_axis_rq_tkeep  = keep_a_s[gidx_q];
    s_axis_rq_tlast  = req_tlast[gidx_q];
    s_axis_rq_tvalid = (state_q == ARB_BUSY) && req_tvalid[gidx_q];
    req_tready       = grant_q & {NUM_REQ{s_axis_rq_tready[0]}};
    beat_last_s      = s_axis_rq_tvalid && s_axis_rq_tready[0] && s_axis_rq_tlast;
  end

  // Arbitration FSM: grant held from first beat through the tlast handshake
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (user_lnk_up && sel_valid_s) begin
            state_q <= ARB_BUSY;
            grant_q <= sel_grant_s;
            gidx_q  <= sel_idx_s;
            busy_q  <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (beat_last_s) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign arb_grant = grant_q;
  assign arb_busy  = busy_q;

`ifdef PCIE_RQ_ARB_STAT_EN
  logic [31:0] cnt_q [NUM_REQ];

  // Completed-packet counters, free-running with natural wrap
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= 32'd0;
      end
    end else if (beat_last_s) begin
      cnt_q[gidx_q] <= cnt_q[gidx_q] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_pkt_cnt[g*32 +: 32] = cnt_q[g];
  end
`endif

endmodule
